shift_unit_arbiter: RTL and testbench

Shares the single combinational barrel shifter (module Shifter) between the two issue lanes of the dual-issue pipeline.
- Decodes each lane's shift op into the shifter's sra/sll controls.
- Arbitrates conflicting requests oldest-first and registers the result into a one-entry output stage with valid/ready backpressure toward writeback.
- Counts conflict stalls for performance monitoring.

---
 rtl/shift_pkg.sv | 28 ++
 rtl/Shifter.sv | 22 ++
 rtl/shift_lane_arb.sv | 42 ++++
 rtl/shift_unit_arbiter.sv | 133 +++++++++++++
 tb/tb_shift_unit_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and decode helper for the shared shift unit.
package shift_pkg;

  // Shift operation encoding as carried by each issue lane.
  typedef enum logic [1:0] {
    SRL  = 2'b00,
    SLL  = 2'b01,
    SRA  = 2'b10,
    RSVD = 2'b11
  } shift_op_t;

  localparam int TAG_W_DEFAULT = 6;

  // Returns {sra, sll}. The reserved code decodes as a logical right shift,
  // so the shifter never sees both controls asserted.
  function automatic logic [1:0] shift_ctrl(input shift_op_t op);
    logic [1:0] ctrl;
    case (op)
      SRL:     ctrl = 2'b00;
      SLL:     ctrl = 2'b01;
      SRA:     ctrl = 2'b10;
      RSVD:    ctrl = 2'b00;
      default: ctrl = 2'b00;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/Shifter.sv
// Combinational 32-bit barrel shifter shared by both issue lanes.
module Shifter (
  input  logic [31:0] in,
  input  logic [4:0]  size,
  input  logic        sra,
  input  logic        sll,
  output logic [31:0] out
);

  // Select shift direction/kind; logical right shift when neither control is set.
  always_comb begin
    out = 32'h0000_0000;
    if (sll) begin
      out = in << size;
    end else if (sra) begin
      out = $unsigned($signed(in) >>> size);
    end else begin
      out = in >> size;
    end
  end

endmodule

// File: rtl/shift_lane_arb.sv
// Two-requester oldest-first arbiter for a shared single-issue unit.
// Requester 0 is the older slot; a requester 1 that lost to requester 0
// is remembered and granted ahead of any newer requester 0 work.
module shift_lane_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic can_issue,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel
);

  logic hold_r;
  logic win1_s;

  // Pick the winner and qualify the grants with downstream availability.
  always_comb begin
    win1_s = hold_r || (!req0 && req1);
    gnt0   = can_issue && req0 && !win1_s;
    gnt1   = can_issue && req1 && win1_s;
    sel    = win1_s;
  end

  // Remember a deferred requester 1 until it is accepted or flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_r <= 1'b0;
    end else if (flush) begin
      hold_r <= 1'b0;
    end else if (gnt1) begin
      hold_r <= 1'b0;
    end else if (req1 && gnt0) begin
      hold_r <= 1'b1;
    end else begin
      hold_r <= hold_r;
    end
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one barrel shifter between two issue lanes with a one-entry
// registered result stage and a saturating conflict-stall counter.
module shift_unit_arbiter
  import shift_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             l0_valid,
  output logic             l0_ready,
  input  logic [1:0]       l0_op,
  input  logic [31:0]      l0_a,
  input  logic [4:0]       l0_b,
  input  logic [TAG_W-1:0] l0_tag,
  input  logic             l1_valid,
  output logic             l1_ready,
  input  logic [1:0]       l1_op,
  input  logic [31:0]      l1_a,
  input  logic [4:0]       l1_b,
  input  logic [TAG_W-1:0] l1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_lane,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             res_valid_r;
  logic [31:0]      res_data_r;
  logic [TAG_W-1:0] res_tag_r;
  logic             res_lane_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic             can_issue_s;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             sel_s;
  logic             accept_s;
  logic [1:0]       win_op_s;
  logic [31:0]      win_a_s;
  logic [4:0]       win_b_s;
  logic [TAG_W-1:0] win_tag_s;
  logic [1:0]       ctrl_s;
  logic [31:0]      shift_out_s;

  // The result stage can take a new op when it is empty or draining this cycle.
  always_comb begin
    can_issue_s = !flush && rst_n && (!res_valid_r || res_ready);
  end

  shift_lane_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .can_issue (can_issue_s),
    .req0      (l0_valid),
    .req1      (l1_valid),
    .gnt0      (gnt0_s),
    .gnt1      (gnt1_s),
    .sel       (sel_s)
  );

  // Steer the winning lane's payload to the shifter and decode its op.
  always_comb begin
    if (sel_s) begin
      win_op_s  = l1_op;
      win_a_s   = l1_a;
      win_b_s   = l1_b;
      win_tag_s = l1_tag;
    end else begin
      win_op_s  = l0_op;
      win_a_s   = l0_a;
      win_b_s   = l0_b;
      win_tag_s = l0_tag;
    end
    ctrl_s   = shift_ctrl(shift_op_t'(win_op_s));
    accept_s = gnt0_s || gnt1_s;
  end

  Shifter u_shifter (
    .in   (win_a_s),
    .size (win_b_s),
    .sra  (ctrl_s[1]),
    .sll  (ctrl_s[0]),
    .out  (shift_out_s)
  );

  // One-entry result stage: load on accept, drain on handshake, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= 32'h0000_0000;
      res_tag_r   <= {TAG_W{1'b0}};
      res_lane_r  <= 1'b0;
    end else if (flush) begin
      res_valid_r <= 1'b0;
    end else if (accept_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= shift_out_s;
      res_tag_r   <= win_tag_s;
      res_lane_r  <= sel_s;
    end else if (res_valid_r && res_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  // Count cycles where both lanes asked and only one could go; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (l0_valid && l1_valid && can_issue_s &&
                 (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign l0_ready  = gnt0_s;
  assign l1_ready  = gnt1_s;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_tag   = res_tag_r;
  assign res_lane  = res_lane_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: vector table plus hand-built sequences.
module tb_shift_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        l0_valid, l1_valid;
  logic        l0_ready, l1_ready;
  logic [1:0]  l0_op, l1_op;
  logic [31:0] l0_a, l1_a;
  logic [4:0]  l0_b, l1_b;
  logic [5:0]  l0_tag, l1_tag;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [5:0]  res_tag;
  logic        res_lane;
  logic [15:0] stall_cnt;

  logic        sat_l0_valid, sat_l1_valid;
  logic        sat_l0_ready, sat_l1_ready;
  logic        sat_res_valid;
  logic [31:0] sat_res_data;
  logic [5:0]  sat_res_tag;
  logic        sat_res_lane;
  logic [3:0]  sat_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_unit_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .l0_valid(l0_valid), .l0_ready(l0_ready), .l0_op(l0_op), .l0_a(l0_a),
    .l0_b(l0_b), .l0_tag(l0_tag),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_a(l1_a),
    .l1_b(l1_b), .l1_tag(l1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_lane(res_lane), .stall_cnt(stall_cnt)
  );

  shift_unit_arbiter #(.TAG_W(6), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .l0_valid(sat_l0_valid), .l0_ready(sat_l0_ready), .l0_op(2'b01),
    .l0_a(32'h0000_0001), .l0_b(5'd1), .l0_tag(6'd1),
    .l1_valid(sat_l1_valid), .l1_ready(sat_l1_ready), .l1_op(2'b00),
    .l1_a(32'h0000_0008), .l1_b(5'd1), .l1_tag(6'd2),
    .res_valid(sat_res_valid), .res_ready(1'b1), .res_data(sat_res_data),
    .res_tag(sat_res_tag), .res_lane(sat_res_lane), .stall_cnt(sat_stall_cnt)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  b;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester-rule monitor: a pending request must stay up with stable payload.
  logic        pend0_r = 1'b0, pend1_r = 1'b0;
  logic [44:0] pay0_r, pay1_r;
  always @(posedge clk) begin
    if (pend0_r && (!l0_valid || {l0_op, l0_a, l0_b, l0_tag} !== pay0_r)) begin
      errors++;
      $display("FAIL requester_rule_l0: lane 0 request changed while pending");
    end
    if (pend1_r && (!l1_valid || {l1_op, l1_a, l1_b, l1_tag} !== pay1_r)) begin
      errors++;
      $display("FAIL requester_rule_l1: lane 1 request changed while pending");
    end
    pend0_r <= l0_valid && !l0_ready && !flush && rst_n;
    pend1_r <= l1_valid && !l1_ready && !flush && rst_n;
    pay0_r  <= {l0_op, l0_a, l0_b, l0_tag};
    pay1_r  <= {l1_op, l1_a, l1_b, l1_tag};
  end

  task automatic drive_l0(input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] b, input logic [5:0] tag);
    l0_valid = 1'b1; l0_op = op; l0_a = a; l0_b = b; l0_tag = tag;
  endtask

  task automatic drive_l1(input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] b, input logic [5:0] tag);
    l1_valid = 1'b1; l1_op = op; l1_a = a; l1_b = b; l1_tag = tag;
  endtask

  task automatic check_res(input string name, input logic [31:0] data,
                           input logic [5:0] tag, input logic lane);
    check({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({name, "_data"}, res_data, data);
    check({name, "_tag"}, {26'd0, res_tag}, {26'd0, tag});
    check({name, "_lane"}, {31'd0, res_lane}, {31'd0, lane});
  endtask

  initial begin
    vecs[0] = '{2'b10, 32'h8000_0000, 5'd4,  6'd5,  32'hF800_0000};
    vecs[1] = '{2'b01, 32'h0000_0001, 5'd31, 6'd6,  32'h8000_0000};
    vecs[2] = '{2'b00, 32'hF000_0000, 5'd28, 6'd7,  32'h0000_000F};
    vecs[3] = '{2'b10, 32'h1234_5678, 5'd0,  6'd8,  32'h1234_5678};
    vecs[4] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  6'd9,  32'hDEAD_BEEF};
    vecs[5] = '{2'b00, 32'hCAFE_F00D, 5'd0,  6'd10, 32'hCAFE_F00D};
    vecs[6] = '{2'b11, 32'h8000_0000, 5'd1,  6'd11, 32'h4000_0000};
    vecs[7] = '{2'b10, 32'h7FFF_FFF0, 5'd4,  6'd12, 32'h07FF_FFFF};
    vecs[8] = '{2'b01, 32'h0000_ABCD, 5'd8,  6'd13, 32'h00AB_CD00};
    vecs[9] = '{2'b10, 32'hFFFF_FF00, 5'd8,  6'd14, 32'hFFFF_FFFF};

    rst_n = 1'b0; flush = 1'b0; res_ready = 1'b1;
    l0_valid = 1'b0; l0_op = 2'b00; l0_a = 32'h0; l0_b = 5'd0; l0_tag = 6'd0;
    l1_valid = 1'b0; l1_op = 2'b00; l1_a = 32'h0; l1_b = 5'd0; l1_tag = 6'd0;
    sat_l0_valid = 1'b0; sat_l1_valid = 1'b0;

    // Reset: no readiness while held, all outputs cleared.
    tick();
    drive_l0(2'b00, 32'h1, 5'd0, 6'd1);
    #1;
    check("reset_l0_ready", {31'd0, l0_ready}, 32'd0);
    tick();
    check("reset_res_valid", {31'd0, res_valid}, 32'd0);
    check("reset_res_data", res_data, 32'h0);
    check("reset_res_tag", {26'd0, res_tag}, 32'd0);
    check("reset_res_lane", {31'd0, res_lane}, 32'd0);
    check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    l0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Saturation on the CNT_W=4 instance: 20 conflict cycles.
    sat_l0_valid = 1'b1; sat_l1_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("sat_cnt_at_15", {28'd0, sat_stall_cnt}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_cnt_at_20", {28'd0, sat_stall_cnt}, 32'd15);
    check("sat_res_valid", {31'd0, sat_res_valid}, 32'd1);
    check("sat_res_data", sat_res_data, 32'h0000_0004);
    check("sat_res_tag", {26'd0, sat_res_tag}, 32'd2);
    check("sat_res_lane", {31'd0, sat_res_lane}, 32'd1);
    sat_l0_valid = 1'b0; sat_l1_valid = 1'b0;

    // Table of single-lane ops issued back to back.
    for (int i = 0; i < 10; i++) begin
      drive_l0(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      #1;
      check($sformatf("vec%0d_l0_ready", i), {31'd0, l0_ready}, 32'd1);
      tick();
      check_res($sformatf("vec%0d", i), vecs[i].exp, vecs[i].tag, 1'b0);
    end
    l0_valid = 1'b0;
    tick();
    check("drain_res_valid", {31'd0, res_valid}, 32'd0);
    check("no_conflict_stall", {16'd0, stall_cnt}, 32'd0);

    // Conflict: lane 0 first, deferred lane 1 beats a new lane 0 op.
    drive_l0(2'b00, 32'h0000_0100, 5'd4, 6'd1);
    drive_l1(2'b01, 32'h0000_0003, 5'd2, 6'd2);
    #1;
    check("conf0_l0_ready", {31'd0, l0_ready}, 32'd1);
    check("conf0_l1_ready", {31'd0, l1_ready}, 32'd0);
    tick();
    check("conf0_stall", {16'd0, stall_cnt}, 32'd1);
    check_res("conf0", 32'h0000_0010, 6'd1, 1'b0);
    drive_l0(2'b10, 32'h0000_0080, 5'd1, 6'd3);
    #1;
    check("conf1_l0_ready", {31'd0, l0_ready}, 32'd0);
    check("conf1_l1_ready", {31'd0, l1_ready}, 32'd1);
    tick();
    check("conf1_stall", {16'd0, stall_cnt}, 32'd2);
    check_res("conf1", 32'h0000_000C, 6'd2, 1'b1);
    l1_valid = 1'b0;
    #1;
    check("conf2_l0_ready", {31'd0, l0_ready}, 32'd1);
    tick();
    check_res("conf2", 32'h0000_0040, 6'd3, 1'b0);

    // Backpressure: held result, no acceptance, then one transfer plus reload.
    res_ready = 1'b0;
    drive_l0(2'b01, 32'h0000_0005, 5'd1, 6'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_l0_ready", i), {31'd0, l0_ready}, 32'd0);
      tick();
      check_res($sformatf("bp%0d", i), 32'h0000_0040, 6'd3, 1'b0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_l0_ready", {31'd0, l0_ready}, 32'd1);
    tick();
    check_res("bp_reload", 32'h0000_000A, 6'd4, 1'b0);
    l0_valid = 1'b0;
    tick();
    check("bp_drain_valid", {31'd0, res_valid}, 32'd0);

    // Flush with a valid result and a deferred lane 1.
    drive_l0(2'b00, 32'h0000_0100, 5'd4, 6'd6);
    drive_l1(2'b01, 32'h0000_0003, 5'd2, 6'd7);
    tick();
    check_res("fl_pre", 32'h0000_0010, 6'd6, 1'b0);
    check("fl_pre_stall", {16'd0, stall_cnt}, 32'd3);
    flush = 1'b1;
    l0_valid = 1'b0;
    #1;
    check("fl_l1_ready", {31'd0, l1_ready}, 32'd0);
    tick();
    flush = 1'b0;
    check("fl_res_valid", {31'd0, res_valid}, 32'd0);
    check("fl_stall", {16'd0, stall_cnt}, 32'd3);
    drive_l0(2'b00, 32'h0000_0020, 5'd1, 6'd8);
    #1;
    check("fl_post_l0_ready", {31'd0, l0_ready}, 32'd1);
    check("fl_post_l1_ready", {31'd0, l1_ready}, 32'd0);
    tick();
    check_res("fl_post0", 32'h0000_0010, 6'd8, 1'b0);
    check("fl_post_stall", {16'd0, stall_cnt}, 32'd4);
    l0_valid = 1'b0;
    tick();
    check_res("fl_post1", 32'h0000_000C, 6'd7, 1'b1);
    l1_valid = 1'b0;

    // Reset asserted mid-stream discards the loaded result.
    drive_l0(2'b10, 32'h8000_0000, 5'd31, 6'd9);
    tick();
    check_res("mr_load", 32'hFFFF_FFFF, 6'd9, 1'b0);
    l0_valid = 1'b0;
    res_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mr_res_valid", {31'd0, res_valid}, 32'd0);
    check("mr_res_data", res_data, 32'h0);
    check("mr_res_tag", {26'd0, res_tag}, 32'd0);
    check("mr_res_lane", {31'd0, res_lane}, 32'd0);
    check("mr_stall", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
